i2s_receiver: RTL and testbench

Deserializes the audio codec's ADC stream (`adc_serial_data`) framed by externally generated `audio_bit_clk` and `lr_clk` into parallel 24-bit left/right samples, all in the `clk` domain. It is the receive end of the same I2S link the playback path drives toward the DAC. Its outputs feed `sound_dataL`/`sound_dataR` and the `data_ready` input of the memory controller's record path.

---
 rtl/i2s_pkg.sv | 15 +
 rtl/i2s_receiver_if.sv | 27 ++
 rtl/i2s_sync_edge.sv | 35 +++
 rtl/i2s_receiver.sv | 170 +++++++++++++++++
 tb/tb_i2s_receiver.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/i2s_pkg.sv
// i2s_pkg: shared constants and FSM state type for the I2S receive path.
// Holds default widths, synchronizer depth and the slot-tracking state enum.
package i2s_pkg;

    localparam int DATA_W_DEFAULT = 24;
    localparam int SLOT_W_DEFAULT = 32;
    localparam int SYNC_DEPTH     = 2;

    typedef enum logic [1:0] {
        IDLE,
        LEFT,
        RIGHT
    } rx_state_t;

endpackage

// File: rtl/i2s_receiver_if.sv
// i2s_receiver_if: parallel frame output bundle of the I2S receiver.
// master = receiver (drives samples, data_ready, overrun); slave = consumer (drives data_ack).
interface i2s_receiver_if #(
    parameter int DATA_W = i2s_pkg::DATA_W_DEFAULT
);
    logic [DATA_W-1:0] sound_dataL;
    logic [DATA_W-1:0] sound_dataR;
    logic              data_ready;
    logic              data_ack;
    logic              overrun;

    modport master (
        output sound_dataL,
        output sound_dataR,
        output data_ready,
        output overrun,
        input  data_ack
    );

    modport slave (
        input  sound_dataL,
        input  sound_dataR,
        input  data_ready,
        input  overrun,
        output data_ack
    );
endinterface

// File: rtl/i2s_sync_edge.sv
// i2s_sync_edge: 2-flop synchronizer plus edge register for one async input.
// Ports: clk, rst, i_async in; o_level (aligned with edges), o_rise, o_fall out (registered).
module i2s_sync_edge
    import i2s_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_DEPTH:0] r_sh;
    logic                r_rise;
    logic                r_fall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sh   <= '0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_sh   <= {r_sh[SYNC_DEPTH-1:0], i_async};
            r_rise <= r_sh[SYNC_DEPTH-1] & ~r_sh[SYNC_DEPTH];
            r_fall <= ~r_sh[SYNC_DEPTH-1] & r_sh[SYNC_DEPTH];
        end
    end

    // Edge flags are registered, so the level they describe is the last stage.
    assign o_level = r_sh[SYNC_DEPTH];
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule

// File: rtl/i2s_receiver.sv
// i2s_receiver: deserializes I2S ADC data into parallel left/right samples in the clk domain.
// Ports: clk, rst (async high), en, audio_bit_clk, lr_clk, adc_serial_data; bus (master) carries
// sound_dataL/R, data_ready, overrun and data_ack. Define I2S_RX_OVERRUN_EN for a sticky overrun flag.
module i2s_receiver
    import i2s_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int SLOT_W = SLOT_W_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            audio_bit_clk,
    input  logic            lr_clk,
    input  logic            adc_serial_data,
    i2s_receiver_if.master  bus
);

    localparam int CNT_W = (SLOT_W > 1) ? $clog2(SLOT_W) : 1;

    logic              w_bclk_lvl;
    logic              w_bclk_rise;
    logic              w_bclk_fall;
    logic              w_lr_lvl;
    logic              w_lr_srise;
    logic              w_lr_sfall;
    logic              w_unused;

    logic [SYNC_DEPTH:0] r_dat_sh;
    logic              r_lr_prev;
    rx_state_t         r_state;
    rx_state_t         w_next;
    logic [CNT_W-1:0]  r_bitcnt;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] r_hold_l;
    logic [DATA_W-1:0] r_data_l;
    logic [DATA_W-1:0] r_data_r;
    logic              r_ready;

    logic              w_lr_fall;
    logic              w_lr_rise;
    logic              w_start;
    logic              w_shift;
    logic              w_latch_l;
    logic              w_publish;
    logic [DATA_W-1:0] w_mask;

    i2s_sync_edge u_bclk (
        .clk     (clk),
        .rst     (rst),
        .i_async (audio_bit_clk),
        .o_level (w_bclk_lvl),
        .o_rise  (w_bclk_rise),
        .o_fall  (w_bclk_fall)
    );

    i2s_sync_edge u_lr (
        .clk     (clk),
        .rst     (rst),
        .i_async (lr_clk),
        .o_level (w_lr_lvl),
        .o_rise  (w_lr_srise),
        .o_fall  (w_lr_sfall)
    );

    // Word-select changes between bclk rises; compare against the value seen on the last rise.
    assign w_unused  = ^{w_bclk_lvl, w_bclk_fall, w_lr_srise, w_lr_sfall};
    assign w_lr_fall = w_bclk_rise & r_lr_prev & ~w_lr_lvl;
    assign w_lr_rise = w_bclk_rise & ~r_lr_prev & w_lr_lvl;
    assign w_mask    = DATA_W'(1) << (DATA_W - 1 - int'(r_bitcnt));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // The rise on the word-select change carries the prior slot's tail: it only restarts the slot.
    always_comb begin
        w_next    = r_state;
        w_start   = 1'b0;
        w_shift   = 1'b0;
        w_latch_l = 1'b0;
        w_publish = 1'b0;
        if (!en) begin
            w_next = IDLE;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_lr_fall) begin
                        w_next  = LEFT;
                        w_start = 1'b1;
                    end
                end
                LEFT: begin
                    if (w_lr_rise) begin
                        w_next    = RIGHT;
                        w_latch_l = 1'b1;
                        w_start   = 1'b1;
                    end else if (w_bclk_rise) begin
                        w_shift = 1'b1;
                    end
                end
                RIGHT: begin
                    if (w_lr_fall) begin
                        w_next    = LEFT;
                        w_publish = 1'b1;
                        w_start   = 1'b1;
                    end else if (w_bclk_rise) begin
                        w_shift = 1'b1;
                    end
                end
                default: w_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dat_sh  <= '0;
            r_lr_prev <= 1'b0;
            r_bitcnt  <= '0;
            r_shift   <= '0;
            r_hold_l  <= '0;
            r_data_l  <= '0;
            r_data_r  <= '0;
            r_ready   <= 1'b0;
        end else begin
            // Same depth as the word-select level so data lines up with bclk_rise.
            r_dat_sh <= {r_dat_sh[SYNC_DEPTH-1:0], adc_serial_data};
            if (w_bclk_rise) r_lr_prev <= w_lr_lvl;
            if (w_start) begin
                r_bitcnt <= '0;
                r_shift  <= '0;
            end else if (w_shift) begin
                if (int'(r_bitcnt) < DATA_W)
                    r_shift <= r_shift | ({DATA_W{r_dat_sh[SYNC_DEPTH]}} & w_mask);
                if (r_bitcnt != CNT_W'(SLOT_W - 1))
                    r_bitcnt <= r_bitcnt + 1'b1;
            end
            if (w_latch_l) r_hold_l <= r_shift;
            if (w_publish) begin
                r_data_l <= r_hold_l;
                r_data_r <= r_shift;
                r_ready  <= 1'b1;
            end else if (bus.data_ack && r_ready) begin
                r_ready <= 1'b0;
            end
        end
    end

    assign bus.sound_dataL = r_data_l;
    assign bus.sound_dataR = r_data_r;
    assign bus.data_ready  = r_ready;

`ifdef I2S_RX_OVERRUN_EN
    logic r_overrun;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_overrun <= 1'b0;
        else if (w_publish && r_ready && !bus.data_ack)
            r_overrun <= 1'b1;
    end

    assign bus.overrun = r_overrun;
`else
    assign bus.overrun = 1'b0;
`endif

endmodule

// File: tb/tb_i2s_receiver.sv
// tb_i2s_receiver: randomized I2S transmitter, frame-level reference model and scoreboard
// monitor for i2s_receiver (24-bit samples, 32-bclk nominal slots).
module tb_i2s_receiver;

    localparam int DW   = 24;
    localparam int PER  = 10;
    localparam int HALF = 16;
`ifdef I2S_RX_OVERRUN_EN
    localparam bit OVR_EN = 1'b1;
`else
    localparam bit OVR_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic en    = 1'b0;
    logic bclk  = 1'b1;
    logic lr    = 1'b1;
    logic sdata = 1'b0;

    always #(PER / 2) clk = ~clk;

    i2s_receiver_if #(.DATA_W(DW)) bus ();

    i2s_receiver #(.DATA_W(DW), .SLOT_W(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .en              (en),
        .audio_bit_clk   (bclk),
        .lr_clk          (lr),
        .adc_serial_data (sdata),
        .bus             (bus)
    );

    typedef struct {
        logic [DW-1:0] l;
        logic [DW-1:0] r;
        time           t;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    // frame-level model state: 0 unaligned, 1 inside aligned left, 2 inside right with valid left
    int            al = 0;
    logic [DW-1:0] last_cap = '0;
    logic [DW-1:0] exp_l = '0;
    logic [DW-1:0] m_last_l = '0;
    logic [DW-1:0] m_last_r = '0;
    time           t_rise = 0;
    bit            auto_ack = 1'b1;
    bit            exp_ovr = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    // Sample = first (nb-1) bits received after the discarded rise, MSB first, zero filled.
    function automatic logic [DW-1:0] capture(input logic [DW-1:0] w, input int nb);
        int n;
        n = nb - 1;
        if (n >= DW) return w;
        if (n <= 0) return '0;
        return (w >> (DW - n)) << (DW - n);
    endfunction

    task automatic model_start(input bit lrv);
        if (!lrv) begin
            if (al == 2) begin
                q.push_back('{exp_l, last_cap, t_rise});
                m_last_l = exp_l;
                m_last_r = last_cap;
            end
            al = en ? 1 : 0;
        end else begin
            exp_l = last_cap;
            al = (al == 1) ? 2 : 0;
        end
    endtask

    // ev: 0 none, 1 drop en for a few cycles, 2 pulse rst; applied at bclk fall ev_k
    task automatic slot(input bit lrv, input logic [DW-1:0] w, input int nb,
                        input int ev, input int ev_k);
        logic [DW-1:0] tmp;
        int            wt;
        for (int k = 0; k < nb; k++) begin
            bclk = 1'b0;
            if (k == 0) lr = lrv;
            if (k >= 1 && k <= DW) begin
                tmp   = w << (k - 1);
                sdata = tmp[DW-1];
            end else begin
                sdata = 1'($urandom);
            end
            wt = HALF;
            if (ev == 1 && k == ev_k) begin
                en = 1'b0;
                al = 0;
                repeat (4) @(negedge clk);
                en = 1'b1;
                chk("held_L", 32'(bus.sound_dataL), 32'(m_last_l));
                chk("held_R", 32'(bus.sound_dataR), 32'(m_last_r));
                wt = HALF - 4;
            end else if (ev == 2 && k == ev_k) begin
                rst = 1'b1;
                al  = 0;
                repeat (2) @(negedge clk);
                chk("rst_L", 32'(bus.sound_dataL), 0);
                chk("rst_R", 32'(bus.sound_dataR), 0);
                chk("rst_rdy", 32'(bus.data_ready), 0);
                chk("rst_ovr", 32'(bus.overrun), 0);
                rst = 1'b0;
                wt = HALF - 2;
            end
            repeat (wt) @(negedge clk);
            bclk   = 1'b1;
            t_rise = $time;
            if (k == 0) model_start(lrv);
            repeat (HALF) @(negedge clk);
        end
        last_cap = capture(w, nb);
    endtask

    task automatic frame(input logic [DW-1:0] l, input logic [DW-1:0] r,
                         input int nbl, input int nbr, input int ev, input int ev_k);
        slot(1'b0, l, nbl, (ev == 1) ? 1 : 0, ev_k);
        slot(1'b1, r, nbr, (ev == 2) ? 2 : 0, ev_k);
    endtask

    // Scoreboard monitor: a frame shows up as data_ready rising or new values while ready.
    bit            prev_rdy = 1'b0;
    bit            ack_pend = 1'b0;
    logic [DW-1:0] prev_l = '0;
    logic [DW-1:0] prev_r = '0;
    exp_t          e;

    always @(negedge clk) begin
        if (rst) begin
            prev_rdy     = 1'b0;
            ack_pend     = 1'b0;
            bus.data_ack = 1'b0;
            exp_ovr      = 1'b0;
            prev_l       = '0;
            prev_r       = '0;
        end else begin
            if (ack_pend) begin
                ack_pend     = 1'b0;
                bus.data_ack = 1'b0;
                chk("ack_drop", 32'(bus.data_ready), 0);
            end else if (bus.data_ready && (!prev_rdy || bus.sound_dataL != prev_l ||
                                            bus.sound_dataR != prev_r)) begin
                if (q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_frame: got L=%0h R=%0h, expected none",
                             bus.sound_dataL, bus.sound_dataR);
                end else begin
                    e = q.pop_front();
                    if (prev_rdy && OVR_EN) exp_ovr = 1'b1;
                    chk("frame_L", 32'(bus.sound_dataL), 32'(e.l));
                    chk("frame_R", 32'(bus.sound_dataR), 32'(e.r));
                    chk("latency", 32'($time - e.t), 32'(4 * PER));
                    chk("overrun", 32'(bus.overrun), 32'(exp_ovr));
                end
            end
            if (auto_ack && bus.data_ready && !ack_pend) begin
                bus.data_ack = 1'b1;
                ack_pend     = 1'b1;
            end
            prev_rdy = bus.data_ready;
            prev_l   = bus.sound_dataL;
            prev_r   = bus.sound_dataR;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_L", 32'(bus.sound_dataL), 0);
        chk("reset_R", 32'(bus.sound_dataR), 0);
        chk("reset_rdy", 32'(bus.data_ready), 0);
        chk("reset_ovr", 32'(bus.overrun), 0);

        // disabled: frames on the wire must produce nothing
        slot(1'b1, 24'($urandom), 32, 0, 0);
        frame(24'($urandom), 24'($urandom), 32, 32, 0, 0);
        frame(24'($urandom), 24'($urandom), 32, 32, 0, 0);
        chk("disabled_rdy", 32'(bus.data_ready), 0);

        en = 1'b1;
        frame(24'hA5F00F, 24'h123456, 32, 32, 0, 0);
        frame(24'($urandom), 24'($urandom), 32, 32, 0, 0);

        // withhold ack across two publishes
        auto_ack = 1'b0;
        frame(24'($urandom), 24'($urandom), 32, 32, 0, 0);
        frame(24'($urandom), 24'($urandom), 32, 32, 0, 0);
        chk("withheld_rdy", 32'(bus.data_ready), 1);
        chk("withheld_ovr", 32'(bus.overrun), 32'(OVR_EN));
        auto_ack = 1'b1;

        // short left slot: 16 data bits before the word-select change
        frame(24'hBEEF00 | 24'($urandom_range(255, 0)), 24'($urandom), 17, 32, 0, 0);

        for (int i = 0; i < 3; i++)
            frame(24'($urandom), 24'($urandom),
                  $urandom_range(32, 20), $urandom_range(32, 20), 0, 0);

        // mid-left disable, then realign
        frame(24'($urandom), 24'($urandom), 32, 32, 1, 10);
        frame(24'($urandom), 24'($urandom), 32, 32, 0, 0);
        frame(24'($urandom), 24'($urandom), 32, 32, 0, 0);

        // async reset during a right slot, then realign
        frame(24'($urandom), 24'($urandom), 32, 32, 2, 8);
        frame(24'($urandom), 24'($urandom), 32, 32, 0, 0);
        frame(24'($urandom), 24'($urandom), 32, 32, 0, 0);
        slot(1'b0, 24'($urandom), 32, 0, 0);

        repeat (20) @(negedge clk);
        chk("queue_empty", 32'(q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
